upconverter_ctrl: RTL
=====================

# upconverter_ctrl

Sequencer and sample scheduler in front of the OSERDES-based I/Q upconverter. Holds the serializer in reset until the clocking is locked and settled, then buffers a valid/ready stream of 1-bit I/Q pairs from the MASH modulators. It drives exactly one I/Q pair per `aclk` cycle into the upconverter. When no sample is available, it substitutes a zero-mean mute pattern and counts the underflow.

## Interface
- `RST_HOLD_CYCLES`, 16: cycles `locked` must be continuously high before the serializer reset is released; must be ≥ 2.
- `FIFO_DEPTH`, 8: sample buffer depth; power of two, ≥ 4.
- `UNDERFLOW_CNT_W`, 16: width of the underflow counter.
- `aclk`  in  1  clock; same as the upconverter `CLKDIV`.
- `rst_n`  in  1  asynchronous active-low reset.
- `locked`  in  1  clocking-wizard lock; synchronous to `aclk`.
- `enable`  in  1  level; 1 = stream samples, 0 = drain and mute.
- `s_axis_tdata`  in  2  bit0 = I, bit1 = Q.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tready`  out  1  sample accepted on `tvalid && tready`.
- `data_i`, `data_q`  out  1 each  registered I/Q bits to the upconverter.
- `serdes_rst_n`  out  1  registered active-low reset to the upconverter.
- `running`  out  1  high in RUN.
- `underflow_pulse`  out  1  one-cycle pulse per mute cycle inserted in RUN.
- `underflow_cnt`  out  `UNDERFLOW_CNT_W`  saturating underflow count.

## Operation
- States: HOLD, IDLE, PRIME, RUN, DRAIN.
- **HOLD** (reset state):
  - `serdes_rst_n`=0; FIFO flushed; `tready`=0.
  - Hold counter increments while `locked`=1 and clears while `locked`=0.
  - At count `RST_HOLD_CYCLES-1` with `locked`=1 → IDLE.
- **IDLE**:
  - `serdes_rst_n`=1, mute output, `tready`=0.
  - `enable`=1 → PRIME.
- **PRIME**:
  - `tready`=!full; mute output.
  - FIFO occupancy ≥ `FIFO_DEPTH/2` → RUN.
  - `enable`=0 → DRAIN.
- **RUN**:
  - `tready`=!full.
  - FIFO non-empty: pop head onto `data_i`/`data_q`.
  - FIFO empty: emit the mute pattern, pulse `underflow_pulse`, increment `underflow_cnt` (saturates at all-ones, no wrap).
  - `enable`=0 → DRAIN.
- **DRAIN**:
  - `tready`=0; pop one entry per cycle.
  - First cycle with the FIFO empty: emit mute, no underflow count, → IDLE.
  - `enable`=1 during DRAIN is ignored until IDLE is reached.
- **Mute pattern**:
  - A phase bit toggles every cycle in which mute is emitted and is cleared on entering HOLD.
  - `data_i`=`data_q`=phase, giving serializer words 1001/0110 alternately (zero mean).
- **`locked`=0 in any non-HOLD state**: → HOLD next edge; `serdes_rst_n`=0 on that edge; FIFO flushed; `underflow_cnt` retained.
- **FIFO rules**:
  - No push when full.
  - Simultaneous push and pop on a non-empty FIFO leaves occupancy unchanged.
  - No bypass: a sample pushed into an empty FIFO is not popped on the same edge.
- **`underflow_cnt`** clears only on `rst_n`.

## Timing
- **Reset values:**
  - `serdes_rst_n`=0, `data_i`=0, `data_q`=0, `tready`=0.
  - `running`=0, `underflow_pulse`=0, `underflow_cnt`=0, state HOLD.
- **Reset release timing:**
  - With `locked` high from reset release, `serdes_rst_n` rises on the edge after `RST_HOLD_CYCLES` sampled-high cycles.
- **Data latency:**
  - A sample accepted at edge N into an empty FIFO in RUN is registered onto `data_i`/`data_q` at edge N+1 at the earliest.
  - Steady-state throughput is one sample per cycle, no bubbles.
- **Status outputs:**
  - `running` is registered and asserts on the edge that enters RUN.
  - `underflow_pulse` is aligned with the mute sample it flags.
- **Outputs:** all outputs are registered; no combinational input-to-output paths except `tready` (from state and full flag).

## Structure
- **`upconverter_pkg`:**
  - State enum `upc_state_t`.
  - Packed struct `iq_t` {q, i}.
  - Localparams for the mute phase reset value and the PRIME threshold.
- **Sub-module `iq_fifo`:**
  - Synchronous FIFO of `iq_t`, parameterised by depth.
  - Outputs full, empty and count; flush input; asynchronous active-low reset.

## Test plan
- **Reset release:**
  - Stimulus: `locked` high from reset release; glitch low at cycle 10; high again.
  - Required: `serdes_rst_n` rises exactly 16 cycles after the glitch ends; outputs stay 0 until then.
- **Prime and stream:**
  - Stimulus: `enable`=1; stream I/Q = 01,10,11,00 repeating with `tvalid` always 1.
  - Required: RUN entered after 4 accepts; outputs reproduce the sequence in order with no gaps; `underflow_cnt`=0.
- **Underflow:**
  - Stimulus: in RUN, drop `tvalid` for 3 cycles after the FIFO empties.
  - Required: mute 1,0,1 (or 0,1,0 depending on phase) on both bits; 3 pulses; `underflow_cnt`=3; streaming resumes in order.
- **Drain:**
  - Stimulus: deassert `enable` with 5 entries buffered.
  - Required: `tready` drops the next cycle; 5 samples emitted; then mute, IDLE, no underflow counted.
- **Lock loss:**
  - Stimulus: drop `locked` mid-RUN.
  - Required: next edge `serdes_rst_n`=0, FIFO empty, `running`=0; `underflow_cnt` unchanged.
- **Saturation:**
  - Stimulus: with `UNDERFLOW_CNT_W`=4, force 20 underflows.
  - Required: `underflow_cnt` holds 15; pulses continue.

Source files
------------

// File: rtl/upconverter_pkg.sv
// Shared types and constants for the upconverter sample scheduler.
// No logic; imported by the interface, the FIFO and the controller.
package upconverter_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } upc_state_t;

    typedef struct packed {
        logic q;
        logic i;
    } iq_t;

    localparam logic MUTE_PHASE_RST = 1'b0;
    // PRIME hands over to RUN once the FIFO holds FIFO_DEPTH / PRIME_DIV samples.
    localparam int   PRIME_DIV      = 2;

endpackage

// File: rtl/upconverter_ctrl_if.sv
// Valid/ready stream of 1-bit I/Q pairs from the MASH modulators.
// Transfer happens on tvalid && tready; no data-path state.
interface upconverter_ctrl_if;
    import upconverter_pkg::*;

    iq_t  tdata;
    logic tvalid;
    logic tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/iq_fifo.sv
// Synchronous I/Q sample FIFO: read data is the current head (0-cycle read), writes land next edge.
// Pushes are dropped when full, pops ignored when empty; flush empties it in one cycle.
module iq_fifo
    import upconverter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  iq_t                      wdata,
    input  logic                     pop,
    output iq_t                      rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    iq_t           mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/upconverter_ctrl.sv
// Serializer reset sequencer + sample scheduler: one registered I/Q pair per aclk, mute pattern on underflow.
// Output latency one edge after FIFO pop; tready = !full only in PRIME/RUN, so upstream stalls elsewhere.
module upconverter_ctrl
    import upconverter_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int UNDERFLOW_CNT_W = 16
) (
    input  logic                       aclk,
    input  logic                       rst_n,
    input  logic                       locked,
    input  logic                       enable,
    upconverter_ctrl_if.slave          s_axis,
    output logic                       data_i,
    output logic                       data_q,
    output logic                       serdes_rst_n,
    output logic                       running,
    output logic                       underflow_pulse,
    output logic [UNDERFLOW_CNT_W-1:0] underflow_cnt
);
    localparam int              HCW       = $clog2(RST_HOLD_CYCLES);
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0]   PRIME_LVL = CW'(FIFO_DEPTH / PRIME_DIV);

    upc_state_t     state;
    upc_state_t     state_nxt;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_nxt;
    logic           phase;
    logic           tready;
    logic           push;
    logic           pop;
    logic           mute;
    logic           uflow;
    logic           flush;
    iq_t            fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    assign tready        = ((state == ST_PRIME) || (state == ST_RUN)) && !fifo_full;
    assign s_axis.tready = tready;
    assign push          = s_axis.tvalid && tready;

    iq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (s_axis.tdata),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        pop       = 1'b0;
        mute      = 1'b0;
        uflow     = 1'b0;
        flush     = 1'b0;
        // Lock loss overrides everything, including a sample accepted on this edge.
        if ((state != ST_HOLD) && !locked) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            flush     = 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    flush = 1'b1;
                    if (!locked) begin
                        hold_nxt = '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_IDLE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HCW'(1);
                    end
                end
                ST_IDLE: begin
                    mute = 1'b1;
                    if (enable) begin
                        state_nxt = ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    mute = 1'b1;
                    if (!enable) begin
                        state_nxt = ST_DRAIN;
                    end else if (fifo_count >= PRIME_LVL) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        mute  = 1'b1;
                        uflow = 1'b1;
                    end
                    if (!enable) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        mute      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_HOLD;
            hold_cnt        <= '0;
            phase           <= MUTE_PHASE_RST;
            data_i          <= 1'b0;
            data_q          <= 1'b0;
            serdes_rst_n    <= 1'b0;
            running         <= 1'b0;
            underflow_pulse <= 1'b0;
            underflow_cnt   <= '0;
        end else begin
            state           <= state_nxt;
            hold_cnt        <= hold_nxt;
            serdes_rst_n    <= (state_nxt != ST_HOLD);
            running         <= (state_nxt == ST_RUN);
            underflow_pulse <= uflow;
            if (pop) begin
                data_i <= fifo_head.i;
                data_q <= fifo_head.q;
            end else if (mute) begin
                data_i <= phase;
                data_q <= phase;
            end else begin
                data_i <= 1'b0;
                data_q <= 1'b0;
            end
            // Equal I and Q bits serialize to 1001/0110 alternately: zero mean.
            if (state_nxt == ST_HOLD) begin
                phase <= MUTE_PHASE_RST;
            end else if (mute) begin
                phase <= ~phase;
            end
            if (uflow && (underflow_cnt != '1)) begin
                underflow_cnt <= underflow_cnt + UNDERFLOW_CNT_W'(1);
            end
        end
    end

endmodule
